// File: rtl/sdm.sv
`default_nettype none
// ============================================================================
//  Module      : sdm
//  Description : Fractional sigma-delta modulator producing a 2-bit output
//                whose long-term mean equals I + F/64 of the 8-bit target
//                s_os. Selectable 1st-order or 2nd-order (MASH 1-1) noise
//                shaping, with an optional thermometer-coded copy of the
//                output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdm (
   input  logic       nsh_clk,
   input  logic       csr_flb_sdm_en,
   input  logic [7:0] s_os,
   input  logic       csr_flb_sdm_order,
   input  logic       csr_flb_sdm_thrm_en,
   output logic [1:0] os_bin,
   output logic [2:0] os_thrm
);

   localparam logic [2:0] THRM_0 = 3'b000;
   localparam logic [2:0] THRM_1 = 3'b001;
   localparam logic [2:0] THRM_2 = 3'b011;
   localparam logic [2:0] THRM_3 = 3'b111;

   // Integer and fractional parts of the target
   logic [1:0] int_part;
   logic [5:0] frac_part;

   // Accumulator state
   logic [5:0] acc1_q, acc1_d;
   logic [5:0] acc2_q, acc2_d;
   logic       c2_d_q, c2_d_d;

   // Output registers
   logic [1:0] os_bin_q, os_bin_d;
   logic [2:0] os_thrm_q, os_thrm_d;

   // Datapath intermediates
   logic [6:0] sum1;
   logic [6:0] sum2;
   logic       c1;
   logic       c2;
   logic [3:0] y_raw;

   assign int_part  = s_os[7:6];
   assign frac_part = s_os[5:0];

   // Next-state for both modulator stages, output combination and saturation
   always_comb begin
      sum1   = {1'b0, acc1_q} + {1'b0, frac_part};
      c1     = sum1[6];
      acc1_d = sum1[5:0];

      // Stage 2 integrates the stage-1 residue; its carry is differentiated
      // (c2 - c2_d) so that its contribution has zero mean.
      sum2   = {1'b0, acc2_q} + {1'b0, acc1_d};
      acc2_d = 6'd0;
      c2_d_d = 1'b0;
      c2     = 1'b0;
      if (csr_flb_sdm_order) begin
         c2     = sum2[6];
         acc2_d = sum2[5:0];
         c2_d_d = c2;
      end

      // 4-bit two's complement holds the full range I-1 .. I+2 (-1 .. 5).
      // In 1st-order mode c2 and c2_d_q are both zero, so this reduces to I+c1.
      y_raw = {2'b00, int_part} + {3'b000, c1} + {3'b000, c2}
              - {3'b000, (csr_flb_sdm_order & c2_d_q)};

      // Negative values have bit 3 set; 4 and 5 have bit 2 set
      if (y_raw[3]) begin
         os_bin_d = 2'd0;
      end else if (y_raw[2]) begin
         os_bin_d = 2'd3;
      end else begin
         os_bin_d = y_raw[1:0];
      end

      os_thrm_d = THRM_0;
      if (csr_flb_sdm_thrm_en) begin
         case (os_bin_d)
            2'd0:    os_thrm_d = THRM_0;
            2'd1:    os_thrm_d = THRM_1;
            2'd2:    os_thrm_d = THRM_2;
            default: os_thrm_d = THRM_3;
         endcase
      end
   end

   // State and output registers; enable low clears all phase asynchronously
   always_ff @(posedge nsh_clk or negedge csr_flb_sdm_en) begin
      if (!csr_flb_sdm_en) begin
         acc1_q    <= 6'd0;
         acc2_q    <= 6'd0;
         c2_d_q    <= 1'b0;
         os_bin_q  <= 2'd0;
         os_thrm_q <= THRM_0;
      end else begin
         acc1_q    <= acc1_d;
         acc2_q    <= acc2_d;
         c2_d_q    <= c2_d_d;
         os_bin_q  <= os_bin_d;
         os_thrm_q <= os_thrm_d;
      end
   end

   assign os_bin  = os_bin_q;
   assign os_thrm = os_thrm_q;

endmodule
`default_nettype wire

// File: tb/tb_sdm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdm
//  Description : Self-checking bench for sdm. A behavioural model computes
//                the expected output when each input vector is driven; the
//                expectation is queued and compared one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdm;

   logic       nsh_clk = 1'b0;
   logic       csr_flb_sdm_en = 1'b0;
   logic [7:0] s_os = 8'd0;
   logic       csr_flb_sdm_order = 1'b0;
   logic       csr_flb_sdm_thrm_en = 1'b0;
   logic [1:0] os_bin;
   logic [2:0] os_thrm;

   sdm dut (
      .nsh_clk             (nsh_clk),
      .csr_flb_sdm_en      (csr_flb_sdm_en),
      .s_os                (s_os),
      .csr_flb_sdm_order   (csr_flb_sdm_order),
      .csr_flb_sdm_thrm_en (csr_flb_sdm_thrm_en),
      .os_bin              (os_bin),
      .os_thrm             (os_thrm)
   );

   always #5 nsh_clk = ~nsh_clk;

   int vectors_applied = 0;
   int miscompares = 0;

   // Reference model state
   int m_acc1 = 0;
   int m_acc2 = 0;
   int m_c2d  = 0;

   // Scoreboard entries: {thermometer, binary}
   logic [4:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors_applied++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc1 = 0;
      m_acc2 = 0;
      m_c2d  = 0;
      exp_q.delete();
   endtask

   // One clock: drive at negedge, push model expectation, compare after posedge
   task automatic step(input logic [7:0] os, input logic ord, input logic te,
                       output logic [1:0] bin);
      int f, i, s1, c1, s2, c2, y;
      logic [2:0] t;
      logic [4:0] e;
      @(negedge nsh_clk);
      s_os = os;
      csr_flb_sdm_order = ord;
      csr_flb_sdm_thrm_en = te;
      f  = int'(os[5:0]);
      i  = int'(os[7:6]);
      s1 = m_acc1 + f;
      c1 = s1 / 64;
      m_acc1 = s1 % 64;
      if (ord) begin
         s2 = m_acc2 + m_acc1;
         c2 = s2 / 64;
         m_acc2 = s2 % 64;
         y = i + c1 + c2 - m_c2d;
         m_c2d = c2;
      end else begin
         m_acc2 = 0;
         m_c2d = 0;
         y = i + c1;
      end
      if (y < 0) y = 0;
      if (y > 3) y = 3;
      case (y)
         0:       t = 3'b000;
         1:       t = 3'b001;
         2:       t = 3'b011;
         default: t = 3'b111;
      endcase
      if (!te) t = 3'b000;
      exp_q.push_back({t, y[1:0]});
      @(posedge nsh_clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         bin = os_bin;
      end else begin
         e = exp_q.pop_front();
         check("os_bin", {30'd0, os_bin}, {30'd0, e[1:0]});
         check("os_thrm", {29'd0, os_thrm}, {29'd0, e[4:2]});
         bin = os_bin;
      end
   endtask

   // Assert enable low between edges, hold it across one edge, release mid-cycle
   task automatic do_reset();
      @(posedge nsh_clk);
      #2;
      csr_flb_sdm_en = 1'b0;
      #1;
      check("rst_os_bin", {30'd0, os_bin}, 32'd0);
      check("rst_os_thrm", {29'd0, os_thrm}, 32'd0);
      check("rst_acc1", {26'd0, dut.acc1_q}, 32'd0);
      model_reset();
      @(posedge nsh_clk);
      #1;
      check("rst_hold_os_bin", {30'd0, os_bin}, 32'd0);
      #1;
      csr_flb_sdm_en = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] b;
      int twos, ones, sum, ext;
      logic [7:0] sat_vals [3];
      sat_vals[0] = 8'h00;
      sat_vals[1] = 8'hC0;
      sat_vals[2] = 8'hFF;

      #12;
      check("por_os_bin", {30'd0, os_bin}, 32'd0);
      check("por_os_thrm", {29'd0, os_thrm}, 32'd0);

      // 1st-order pattern for 0x4A
      do_reset();
      twos = 0; ones = 0;
      for (int k = 1; k <= 64; k++) begin
         step(8'h4A, 1'b0, 1'b1, b);
         if (k <= 6) check("p1_edge_1to6", {30'd0, b}, 32'd1);
         if (k == 7) check("p1_edge_7", {30'd0, b}, 32'd2);
         if (b == 2'd2) twos++;
         if (b == 2'd1) ones++;
      end
      check("p1_twos_64", twos, 32'd10);
      check("p1_ones_64", ones, 32'd54);

      // Saturation / boundary constants
      for (int v = 0; v < 3; v++) begin
         do_reset();
         ext = 0;
         for (int k = 0; k < 256; k++) begin
            step(sat_vals[v], 1'b0, 1'b1, b);
            if (b != ((v == 0) ? 2'd0 : 2'd3)) ext++;
         end
         check("sat_wrong_cycles", ext, 32'd0);
      end

      // 2nd-order MASH mean and excursion
      do_reset();
      sum = 0; ext = 0;
      for (int k = 0; k < 4096; k++) begin
         step(8'h4A, 1'b1, 1'b1, b);
         sum += int'(b);
         if (b == 2'd0 || b == 2'd3) ext++;
      end
      check("mash_sum_in_4734_4738", {31'd0, (sum >= 4734 && sum <= 4738)}, 32'd1);
      check("mash_excursion_seen", {31'd0, (ext > 0)}, 32'd1);

      // Thermometer enabled, then disabled while os_bin keeps toggling
      do_reset();
      for (int k = 0; k < 64; k++) step(8'h4A, 1'b0, 1'b1, b);
      do_reset();
      twos = 0; ones = 0;
      for (int k = 0; k < 64; k++) begin
         step(8'h4A, 1'b0, 1'b0, b);
         if (b == 2'd2) twos++;
         if (b == 2'd1) ones++;
      end
      check("thrm_off_twos", twos, 32'd10);
      check("thrm_off_ones", ones, 32'd54);

      // Mid-run asynchronous reset, then the pattern restarts from edge 1
      do_reset();
      for (int k = 0; k < 20; k++) step(8'h4A, 1'b0, 1'b1, b);
      #2;
      csr_flb_sdm_en = 1'b0;
      #1;
      check("async_os_bin", {30'd0, os_bin}, 32'd0);
      check("async_os_thrm", {29'd0, os_thrm}, 32'd0);
      check("async_acc1", {26'd0, dut.acc1_q}, 32'd0);
      model_reset();
      @(posedge nsh_clk);
      #1;
      check("async_hold_os_bin", {30'd0, os_bin}, 32'd0);
      #1;
      csr_flb_sdm_en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step(8'h4A, 1'b0, 1'b1, b);
         if (k <= 6) check("restart_edge_1to6", {30'd0, b}, 32'd1);
         if (k == 7) check("restart_edge_7", {30'd0, b}, 32'd2);
      end

      // Order switch 2nd -> 1st: stage 2 cleared, acc1 preserved
      do_reset();
      for (int k = 0; k < 30; k++) step(8'h4A, 1'b1, 1'b1, b);
      step(8'h4A, 1'b0, 1'b1, b);
      check("switch_acc2", {26'd0, dut.acc2_q}, 32'd0);
      check("switch_c2_d", {31'd0, dut.c2_d_q}, 32'd0);
      check("switch_acc1", {26'd0, dut.acc1_q}, m_acc1);
      for (int k = 0; k < 20; k++) step(8'h4A, 1'b0, 1'b1, b);

      // Randomised inputs changing every cycle
      do_reset();
      for (int k = 0; k < 400; k++) begin
         step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdm.md
SDM -- requirements
Module: sdm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as stated below.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have port nsh_clk: input, 1 bit, clock; all state updates on its rising edge.
REQ-004 The block SHALL have port csr_flb_sdm_en: input, 1 bit, asynchronous active-low reset / enable; 0 clears all state, 1 runs the modulator.
REQ-005 The block SHALL have port s_os: input, 8 bits, unsigned fixed-point target.
  - s_os[7:6] is the integer part I (0..3).
  - s_os[5:0] is the fraction F (F/64).
REQ-006 The block SHALL have port csr_flb_sdm_order: input, 1 bit; 0 selects 1st-order, 1 selects 2nd-order (MASH 1-1).
REQ-007 The block SHALL have port csr_flb_sdm_thrm_en: input, 1 bit, thermometer output enable.
REQ-008 The block SHALL have port os_bin: output, 2 bits, registered binary modulator output (0..3).
REQ-009 The block SHALL have port os_thrm: output, 3 bits, registered thermometer-coded modulator output.

Function
REQ-010 State SHALL be:
  - acc1, 6 bits;
  - acc2, 6 bits;
  - c2_d, 1 bit, the delayed stage-2 carry;
  - the os_bin and os_thrm registers.
REQ-011 At each rising edge with csr_flb_sdm_en=1, the 7-bit sum acc1+F SHALL give carry c1 (bit 6) and acc1_n (bits 5:0), with acc1 <= acc1_n.
REQ-012 In 1st-order mode, the next output value y SHALL be I + c1, computed as an unsigned 3-bit value.
REQ-013 In 2nd-order mode, the 7-bit sum acc2+acc1_n SHALL give carry c2 and the new acc2, with c2_d <= c2.
REQ-014 In 2nd-order mode, y SHALL be I + c1 + c2 - c2_d, computed as a signed value with range I-1..I+2.
REQ-015 In 1st-order mode, acc2 and c2_d SHALL be loaded with 0 every cycle.
REQ-016 y SHALL saturate: y<0 gives 0, and y>3 gives 3.
REQ-017 os_bin SHALL be loaded with the saturated y at the same edge that updates the accumulators, so latency from s_os sample to os_bin is one clock.
REQ-018 os_thrm SHALL be loaded at the same edge as os_bin as follows:
  - with csr_flb_sdm_thrm_en=1: thermometer of saturated y (0->000, 1->001, 2->011, 3->111);
  - with csr_flb_sdm_thrm_en=0: 000.
REQ-019 s_os, csr_flb_sdm_order and csr_flb_sdm_thrm_en SHALL be sampled every cycle; a change SHALL take effect at the next edge with no pipeline flush.
REQ-020 Accumulator wrap-around SHALL be modulo 64; the carry is the only overflow product.
REQ-021 Over any 64 consecutive cycles in 1st-order mode with constant s_os and no saturation, the sum of os_bin SHALL be exactly 64*I+F.
REQ-022 In 2nd-order mode with constant s_os and no saturation, the long-term mean of os_bin SHALL equal I+F/64.
REQ-023 An order switch from 2nd to 1st SHALL clear acc2/c2_d at the next edge; acc1 SHALL be preserved across any order switch.

Reset
REQ-024 csr_flb_sdm_en=0 SHALL asynchronously clear acc1, acc2, c2_d, os_bin (00) and os_thrm (000), independent of nsh_clk.
REQ-025 Reset SHALL be held while csr_flb_sdm_en=0.
REQ-026 On release, the first rising edge SHALL perform a normal update from zeroed state.
REQ-027 Reset asserted mid-operation SHALL discard all accumulated phase; after release the sequence SHALL restart identically to the one following power-up.

Verification
REQ-028 s_os=0x4A, order 1st, after reset release:
  - edges 1-6 give os_bin=1;
  - edge 7 gives os_bin=2 (acc1 wraps 70->6);
  - over 64 cycles, exactly 10 values of 2 and 54 values of 1.
REQ-029 Constant inputs, order 1st, 256 cycles, saturation:
  - s_os=0x00 -> os_bin=0 every cycle;
  - s_os=0xC0 -> os_bin=3 every cycle;
  - s_os=0xFF -> os_bin=3 every cycle.
REQ-030 s_os=0x4A, order 2nd, 4096 cycles:
  - os_bin values only in 0..3;
  - sum of os_bin over 4096 cycles = 4736 +/-2;
  - at least one value of 0 or 3 appears, exercising the I-1..I+2 excursion.
REQ-031 Thermometer check over a full 0x4A sequence:
  - thrm_en=1: os_thrm equals the thermometer of os_bin every cycle;
  - thrm_en=0: os_thrm=000 while os_bin keeps toggling 1/2.
REQ-032 Drive csr_flb_sdm_en low between clock edges after 20 cycles -> os_bin/os_thrm go to 0 immediately; after release the REQ-028 pattern repeats from edge 1.
REQ-033 Switch order 2nd->1st mid-run -> acc2 and c2_d read 0 after the next edge, and the output follows 1st-order behaviour from that acc1.
